fdc_sd_arbiter: RTL and testbench
=================================

# fdc_sd_arbiter

Parametrised SD-image request arbiter for the floppy subsystem. It collects sector read and write requests from up to DRIVES independent controller or drive channels. It serialises them round-robin onto the single MiST(er)-style SD port, using one `sd_rd`/`sd_wr` bit per image. It steers the sector byte stream to and from the granted channel only, and adds an optional acknowledge timeout with per-channel error reporting.

## Interface
- DRIVES, 2: number of channels/images (1..8).
- LBA_W, 32: LBA width.
- TIMEOUT, 0: max cycles from request assertion to `sd_ack` rise; 0 disables the timeout.
- clk_sys  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_rd  in  DRIVES  per-channel read-sector request (level).
- req_wr  in  DRIVES  per-channel write-sector request (level).
- req_lba  in  DRIVES*LBA_W  per-channel LBA; channel i is at [i*LBA_W +: LBA_W].
- buff_din  in  DRIVES*8  per-channel byte for SD writes; channel i is at [i*8 +: 8].
- busy  out  DRIVES  one-hot; set while channel i owns the SD port.
- done  out  DRIVES  one-cycle pulse; transfer for channel i completed.
- err  out  DRIVES  one-cycle pulse; transfer for channel i aborted by timeout.
- buff_we  out  DRIVES  `sd_buff_wr` gated to the granted channel.
- sd_lba  out  LBA_W  latched LBA of the granted request.
- sd_rd  out  DRIVES  one-hot read strobe to the SD host.
- sd_wr  out  DRIVES  one-hot write strobe to the SD host.
- sd_ack  in  1  SD host acknowledge; high for the whole 512-byte transfer.
- sd_buff_wr  in  1  SD host byte write strobe.
- sd_buff_din  out  8  `buff_din` of the granted channel; 0 when idle.
- `sd_buff_addr`/`sd_buff_dout` are not routed through this block. Clients take them directly.

## Operation
- FSM states: IDLE, REQ, XFER, DONE. A grant index g and a round-robin pointer p are registered.
- IDLE
  - If `sd_ack`=0 and any channel has req_rd|req_wr, grant the first requesting channel at or after p, wrapping at DRIVES.
  - On grant: latch g, `sd_lba`=req_lba[g]. Set `sd_wr[g]` if req_wr[g], otherwise set `sd_rd[g]`; write wins when both are set. Set `busy[g]`. Clear the timeout counter. Go to REQ.
  - No grant is made while `sd_ack`=1, which guards against a stale acknowledge.
- REQ
  - On `sd_ack`=1: clear `sd_rd`/`sd_wr` and go to XFER.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT-1: clear the strobes and `busy`, pulse `err[g]`, set p=g+1 mod DRIVES, return to IDLE.
- XFER
  - `buff_we[g]` follows `sd_buff_wr` combinationally.
  - `sd_buff_din` = buff_din[g], combinationally.
  - On `sd_ack`=0: go to DONE.
- DONE
  - Pulse `done[g]`, clear `busy`, set p=g+1 mod DRIVES, go to IDLE.
- Request rules
  - Requests are sampled only in IDLE. Later changes to req_*/req_lba of the granted channel are ignored until done/err.
  - A client must drop its request on done/err, otherwise it is re-served after a full round.
- Non-granted channels always see `buff_we`=0.
- Counter width is clog2(TIMEOUT+1), minimum 1. The counter saturates and never wraps.

## Timing
- Reset values (asynchronous; reset wins over everything, including mid-transfer): state IDLE, p=0, g=0, `sd_lba`=0, `sd_rd`=0, `sd_wr`=0, `busy`=0, `done`=0, `err`=0.
- `buff_we` and `sd_buff_din` are 0 in reset and outside XFER.
- Grant latency: a request high at edge k gives strobe, `sd_lba` and `busy` valid after edge k+1.
- Strobe deassertion: registered, one cycle after `sd_ack` is first sampled high.
- Completion: `sd_ack` sampled low at edge m gives `done` high for the cycle after edge m+1. The earliest next grant is at edge m+2, so there is a minimum 1 idle cycle between transfers.
- Timeout: `err` is issued exactly TIMEOUT cycles after the strobe rises if no ack arrives.
- Ack ordering: an ack arriving in the same cycle the counter expires is honoured; ack takes priority over timeout.
- `sd_buff_wr`→`buff_we` and `buff_din`→`sd_buff_din` are purely combinational, zero latency.

## Test plan
- Single read, DRIVES=2: req_rd[1]=1, req_lba[1]=0x123; host acks for 512 cycles with `sd_buff_wr` every cycle.
  - Required: `sd_rd`=2'b10 and `sd_lba`=0x123 one cycle after the request.
  - Required: `buff_we[1]` toggles 512 times and `buff_we[0]` stays 0.
  - Required: `done`=2'b10 pulses once.
- Round-robin with channels 0 and 1 requesting continuously: grant order is 0,1,0,1 over four transfers.
- req_rd[0] and req_wr[0] both high: `sd_wr`=2'b01 and `sd_rd`=0. During XFER, `sd_buff_din` equals buff_din[0], with no bytes from channel 1 appearing.
- Timeout, TIMEOUT=16, no ack: `err[0]` pulses 16 cycles after the strobe, then all strobes and `busy` are 0.
  - Repeat with the ack arriving at cycle 15: `done` pulses, `err` stays 0.
- Stale ack: `sd_ack` held high while req_rd[0] rises. Required: no grant until `sd_ack` falls, then grant the next cycle.
- Reset mid-operation: assert reset_n=0 during XFER. Required: all outputs 0 immediately, no `done` pulse. After release, a pending req_rd[1] is granted and p starts at channel 0.

Source files
------------

// File: rtl/fdc_sd_arbiter.sv
// fdc_sd_arbiter: round-robin arbiter that shares one MiST(er)-style SD port
// among DRIVES floppy channels, each with its own sd_rd/sd_wr image bit.
//
// Ports:
//   clk_sys, reset_n        clock, async active-low reset
//   req_rd/req_wr           per-channel sector request levels
//   req_lba, buff_din       per-channel LBA and write byte (packed)
//   busy, done, err         per-channel ownership / completion / timeout
//   buff_we                 sd_buff_wr steered to the granted channel
//   sd_lba, sd_rd, sd_wr    SD host request side
//   sd_ack, sd_buff_wr      SD host acknowledge and byte strobe
//   sd_buff_din             granted channel's write byte (0 when idle)

module fdc_sd_arbiter #(
    parameter int DRIVES  = 2,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [DRIVES-1:0]     req_rd,
    input  logic [DRIVES-1:0]     req_wr,
    input  logic [DRIVES*LBA_W-1:0] req_lba,
    input  logic [DRIVES*8-1:0]   buff_din,
    output logic [DRIVES-1:0]     busy,
    output logic [DRIVES-1:0]     done,
    output logic [DRIVES-1:0]     err,
    output logic [DRIVES-1:0]     buff_we,
    output logic [LBA_W-1:0]      sd_lba,
    output logic [DRIVES-1:0]     sd_rd,
    output logic [DRIVES-1:0]     sd_wr,
    input  logic                  sd_ack,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din
);

    localparam int GW        = (DRIVES > 1) ? $clog2(DRIVES) : 1;
    localparam int CW_RAW    = $clog2(TIMEOUT + 1);
    localparam int CW        = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic [DRIVES-1:0] rd_q, rd_d;
    logic [DRIVES-1:0] wr_q, wr_d;
    logic [DRIVES-1:0] busy_q, busy_d;
    logic [DRIVES-1:0] done_q, done_d;
    logic [DRIVES-1:0] err_q, err_d;

    logic [DRIVES-1:0] req_any;
    logic              found;
    logic [GW-1:0]     pick;
    logic [GW-1:0]     gnt_inc;

    // Channel index a+b, wrapped at DRIVES (b is always < DRIVES).
    function automatic logic [GW-1:0] wrap_add(
        input logic [GW-1:0] a,
        input int            b
    );
        int s;
        s = int'(a) + b;
        if (s >= DRIVES) begin
            s = s - DRIVES;
        end
        return GW'(s);
    endfunction

    assign req_any = req_rd | req_wr;
    assign gnt_inc = wrap_add(gnt_q, 1);

    // First requester at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < DRIVES; k++) begin
            if (!found && req_any[wrap_add(ptr_q, k)]) begin
                found = 1'b1;
                pick  = wrap_add(ptr_q, k);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lba_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = '0;
        err_d   = '0;

        unique case (state_q)
            S_IDLE: begin
                // A still-high ack here belongs to nobody; wait it out.
                if (!sd_ack && found) begin
                    gnt_d = pick;
                    lba_d = req_lba[int'(pick)*LBA_W +: LBA_W];
                    rd_d  = '0;
                    wr_d  = '0;
                    if (req_wr[pick]) begin
                        wr_d[pick] = 1'b1;
                    end else begin
                        rd_d[pick] = 1'b1;
                    end
                    busy_d       = '0;
                    busy_d[pick] = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                // Ack is checked first so it wins on the expiry cycle.
                if (sd_ack) begin
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = S_XFER;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rd_d         = '0;
                    wr_d         = '0;
                    busy_d       = '0;
                    err_d[gnt_q] = 1'b1;
                    ptr_d        = gnt_inc;
                    state_d      = S_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                if (!sd_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d[gnt_q] = 1'b1;
                busy_d        = '0;
                ptr_d         = gnt_inc;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte steering is combinational and only open during the transfer.
    always_comb begin
        buff_we     = '0;
        sd_buff_din = 8'h00;
        if (state_q == S_XFER) begin
            buff_we[gnt_q] = sd_buff_wr;
            sd_buff_din    = buff_din[int'(gnt_q)*8 +: 8];
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign sd_lba = lba_q;
    assign sd_rd  = rd_q;
    assign sd_wr  = wr_q;

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// tb_fdc_sd_arbiter: directed + random stimulus for fdc_sd_arbiter
// (DRIVES=2, TIMEOUT=16) against a transaction-level owner/phase model.

module tb_fdc_sd_arbiter;

    localparam int D  = 2;
    localparam int TO = 16;

    logic        clk_sys;
    logic        reset_n;
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [63:0] req_lba;
    logic [15:0] buff_din;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [1:0]  buff_we;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    fdc_sd_arbiter #(
        .DRIVES (2),
        .LBA_W  (32),
        .TIMEOUT(TO)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_lba    (req_lba),
        .buff_din   (buff_din),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .buff_we    (buff_we),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .sd_buff_wr (sd_buff_wr),
        .sd_buff_din(sd_buff_din)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int we_cnt[2];
    int done_cnt[2];
    int err_cnt[2];
    int glog[$];

    // Model: who owns the port and in which phase of the transaction.
    int          m_owner;
    bit          m_acked;
    bit          m_fin;
    bit          m_wr;
    int          m_wait;
    int          m_rr;
    logic [1:0]  m_done;
    logic [1:0]  m_err;
    logic [31:0] m_lba;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        buff_din = 16'h0000;
        forever begin
            @(posedge clk_sys);
            #1;
            buff_din = 16'($urandom);
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    function automatic int model_pick(input int rr, input logic [1:0] req);
        int r;
        r = -1;
        for (int k = 0; k < D; k++) begin
            if (r < 0 && req[(rr + k) % D]) begin
                r = (rr + k) % D;
            end
        end
        return r;
    endfunction

    initial begin
        m_owner = -1;
        m_acked = 1'b0;
        m_fin   = 1'b0;
        m_wr    = 1'b0;
        m_wait  = 0;
        m_rr    = 0;
        m_done  = 2'b00;
        m_err   = 2'b00;
        m_lba   = 32'h0;
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (!reset_n) begin
                m_owner = -1;
                m_acked = 1'b0;
                m_fin   = 1'b0;
                m_wr    = 1'b0;
                m_wait  = 0;
                m_rr    = 0;
                m_done  = 2'b00;
                m_err   = 2'b00;
                m_lba   = 32'h0;
            end else begin
                m_done = 2'b00;
                m_err  = 2'b00;
                if (m_owner < 0) begin
                    if (!sd_ack && (req_rd | req_wr) != 2'b00) begin
                        m_owner = model_pick(m_rr, req_rd | req_wr);
                        m_wr    = req_wr[m_owner];
                        m_lba   = req_lba[m_owner*32 +: 32];
                        m_acked = 1'b0;
                        m_fin   = 1'b0;
                        m_wait  = 0;
                    end
                end else if (m_fin) begin
                    m_done[m_owner] = 1'b1;
                    m_rr    = (m_owner + 1) % D;
                    m_owner = -1;
                end else if (m_acked) begin
                    if (!sd_ack) m_fin = 1'b1;
                end else if (sd_ack) begin
                    m_acked = 1'b1;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_err[m_owner] = 1'b1;
                        m_rr    = (m_owner + 1) % D;
                        m_owner = -1;
                    end
                end
            end
        end
    end

    // Single compare process: every cycle, all outputs against the model.
    initial begin
        logic [1:0] eb, erd, ewr, ewe, prev_busy;
        logic [7:0] edin;
        bit         xf;
        prev_busy = 2'b00;
        for (int i = 0; i < 2; i++) begin
            we_cnt[i]   = 0;
            done_cnt[i] = 0;
            err_cnt[i]  = 0;
        end
        forever begin
            @(negedge clk_sys);
            eb   = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
            xf   = (m_owner >= 0) && m_acked && !m_fin;
            erd  = (m_owner >= 0 && !m_acked && !m_wr) ? eb : 2'b00;
            ewr  = (m_owner >= 0 && !m_acked && m_wr) ? eb : 2'b00;
            ewe  = (xf && sd_buff_wr) ? eb : 2'b00;
            edin = xf ? buff_din[m_owner*8 +: 8] : 8'h00;
            check("busy", 64'(busy), 64'(eb));
            check("sd_rd", 64'(sd_rd), 64'(erd));
            check("sd_wr", 64'(sd_wr), 64'(ewr));
            check("sd_lba", 64'(sd_lba), 64'(m_lba));
            check("done", 64'(done), 64'(m_done));
            check("err", 64'(err), 64'(m_err));
            check("buff_we", 64'(buff_we), 64'(ewe));
            check("sd_buff_din", 64'(sd_buff_din), 64'(edin));
            for (int i = 0; i < 2; i++) begin
                we_cnt[i]   += int'(buff_we[i]);
                done_cnt[i] += int'(done[i]);
                err_cnt[i]  += int'(err[i]);
            end
            if (prev_busy == 2'b00 && busy != 2'b00) begin
                glog.push_back(busy[1] ? 1 : 0);
            end
            prev_busy = busy;
        end
    end

    task automatic wait_strobe();
        int n;
        n = 0;
        while ((sd_rd | sd_wr) == 2'b00 && n < 60) begin
            tick();
            n++;
        end
        check("strobe_wait", 64'((sd_rd | sd_wr) != 2'b00), 64'(1));
    endtask

    task automatic host_xfer(input int lat, input int n, input bit every);
        repeat (lat) tick();
        sd_ack = 1'b1;
        tick();
        repeat (n) begin
            sd_buff_wr = every ? 1'b1 : 1'($urandom);
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        tick();
    endtask

    initial begin
        int d0, d1, e0, e1, w0, w1, gb, n, hs, hcnt;
        reset_n    = 1'b0;
        req_rd     = 2'b00;
        req_wr     = 2'b00;
        req_lba    = {32'h0000_0123, 32'h00C0_FFEE};
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b1;

        // Reset state, with a stray byte strobe that must stay gated.
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_strobe", 64'(sd_rd | sd_wr), 64'(0));
        check("rst_lba", 64'(sd_lba), 64'(0));
        check("rst_we", 64'(buff_we), 64'(0));
        check("rst_din", 64'(sd_buff_din), 64'(0));
        sd_buff_wr = 1'b0;
        reset_n    = 1'b1;
        tick();

        // Single 512-byte read on channel 1.
        w0 = we_cnt[0];
        w1 = we_cnt[1];
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        req_rd = 2'b10;
        tick();
        check("rd1_sd_rd", 64'(sd_rd), 64'(2'b10));
        check("rd1_lba", 64'(sd_lba), 64'(32'h123));
        check("rd1_busy", 64'(busy), 64'(2'b10));
        req_rd = 2'b00;
        host_xfer(3, 512, 1'b1);
        repeat (3) tick();
        check("rd1_we1_cnt", 64'(we_cnt[1] - w1), 64'(512));
        check("rd1_we0_cnt", 64'(we_cnt[0] - w0), 64'(0));
        check("rd1_done1", 64'(done_cnt[1] - d1), 64'(1));
        check("rd1_done0", 64'(done_cnt[0] - d0), 64'(0));

        // Round-robin with both channels requesting.
        gb = glog.size();
        req_rd = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_strobe();
            if (t == 3) req_rd = 2'b00;
            host_xfer($urandom_range(0, 5), $urandom_range(1, 20), 1'b0);
        end
        repeat (4) tick();
        check("rr_count", 64'(glog.size() - gb), 64'(4));
        for (int t = 0; t < 4; t++) begin
            check("rr_order",
                  64'((glog.size() > gb + t) ? glog[gb + t] : -1),
                  64'(t % 2));
        end

        // Read and write together on channel 0: write wins.
        d0 = done_cnt[0];
        req_rd = 2'b01;
        req_wr = 2'b01;
        wait_strobe();
        check("rw_sd_wr", 64'(sd_wr), 64'(2'b01));
        check("rw_sd_rd", 64'(sd_rd), 64'(2'b00));
        req_rd = 2'b00;
        req_wr = 2'b00;
        sd_ack = 1'b1;
        tick();
        tick();
        check("rw_din", 64'(sd_buff_din), 64'(buff_din[7:0]));
        sd_ack = 1'b0;
        repeat (3) tick();
        check("rw_done0", 64'(done_cnt[0] - d0), 64'(1));

        // Timeout with no ack.
        req_rd = 2'b01;
        wait_strobe();
        n = 0;
        while (err == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("to_cycles", 64'(n), 64'(TO));
        check("to_err", 64'(err), 64'(2'b01));
        req_rd = 2'b00;
        tick();
        check("to_busy", 64'(busy), 64'(0));
        check("to_strobe", 64'(sd_rd | sd_wr), 64'(0));

        // Ack lands on the expiry cycle: transfer wins.
        e0 = err_cnt[0];
        d0 = done_cnt[0];
        req_rd = 2'b01;
        wait_strobe();
        req_rd = 2'b00;
        host_xfer(TO - 1, 8, 1'b0);
        repeat (3) tick();
        check("late_ack_err", 64'(err_cnt[0] - e0), 64'(0));
        check("late_ack_done", 64'(done_cnt[0] - d0), 64'(1));

        // Stale ack blocks grants until it falls.
        sd_ack = 1'b1;
        tick();
        req_rd = 2'b01;
        repeat (5) tick();
        check("stale_busy", 64'(busy), 64'(0));
        sd_ack = 1'b0;
        tick();
        check("stale_grant", 64'(sd_rd), 64'(2'b01));
        req_rd = 2'b00;
        host_xfer(1, 4, 1'b0);
        repeat (3) tick();

        // Reset in the middle of a transfer (pointer is at 1 here).
        req_rd = 2'b01;
        wait_strobe();
        req_rd = 2'b00;
        sd_ack = 1'b1;
        tick();
        sd_buff_wr = 1'b1;
        tick();
        tick();
        d0 = done_cnt[0] + done_cnt[1];
        reset_n = 1'b0;
        #1;
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_strobe", 64'(sd_rd | sd_wr), 64'(0));
        check("mr_we", 64'(buff_we), 64'(0));
        check("mr_din", 64'(sd_buff_din), 64'(0));
        check("mr_lba", 64'(sd_lba), 64'(0));
        check("mr_pulses", 64'(done | err), 64'(0));
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        req_rd     = 2'b11;
        tick();
        reset_n = 1'b1;
        tick();
        check("mr_p0_grant", 64'(sd_rd), 64'(2'b01));
        check("mr_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'(d0));
        req_rd = 2'b10;
        host_xfer(0, 3, 1'b0);
        wait_strobe();
        check("mr_ch1_grant", 64'(sd_rd), 64'(2'b10));
        req_rd = 2'b00;
        host_xfer(0, 3, 1'b0);
        repeat (3) tick();

        // Random clients and host.
        hs   = 0;
        hcnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            req_lba    = {32'($urandom), 32'($urandom)};
            sd_buff_wr = 1'($urandom);
            for (int ch = 0; ch < 2; ch++) begin
                if (done[ch] || err[ch]) begin
                    req_rd[ch] = 1'b0;
                    req_wr[ch] = 1'b0;
                end else if (!req_rd[ch] && !req_wr[ch] &&
                             $urandom_range(0, 5) == 0) begin
                    req_wr[ch] = 1'($urandom);
                    req_rd[ch] = !req_wr[ch] || 1'($urandom);
                end
            end
            case (hs)
                0: begin
                    if ((sd_rd | sd_wr) != 2'b00) begin
                        hcnt = int'($urandom_range(0, 20));
                        hs   = 1;
                    end else if ($urandom_range(0, 40) == 0) begin
                        sd_ack = 1'b1;
                        hcnt   = int'($urandom_range(1, 4));
                        hs     = 3;
                    end
                end
                1: begin
                    if ((sd_rd | sd_wr) == 2'b00) begin
                        hs = 0;
                    end else if (hcnt == 0) begin
                        sd_ack = 1'b1;
                        hcnt   = int'($urandom_range(1, 40));
                        hs     = 2;
                    end else begin
                        hcnt--;
                    end
                end
                default: begin
                    if (hcnt == 0) begin
                        sd_ack = 1'b0;
                        hs     = 0;
                    end else begin
                        hcnt--;
                    end
                end
            endcase
            tick();
        end
        req_rd     = 2'b00;
        req_wr     = 2'b00;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        repeat (40) tick();
        check("final_idle", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
